// File: rtl/system_0_sd_pkg.sv
// Shared constants and FSM state type for the system_0 SD-card SPI byte shifter.
package system_0_sd_pkg;

  localparam logic [1:0] ADDR_TX   = 2'd0;
  localparam logic [1:0] ADDR_RX   = 2'd1;
  localparam logic [1:0] ADDR_STAT = 2'd2;
  localparam logic [1:0] ADDR_DIV  = 2'd3;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_CS      = 8;
  localparam int ST_IRQ_EN  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/system_0_sd_clkgen.sv
// SD_CLK generator: half-period counter, sd_clk toggle and rise/fall/last strobes.
module system_0_sd_clkgen
  import system_0_sd_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sd_clk,
  output logic                 rise,
  output logic                 fall,
  output logic                 last
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [3:0]           half;
  logic                 tick;

  assign tick = run && (cnt == div);
  assign rise = tick && !sd_clk;
  assign fall = tick && sd_clk;
  assign last = tick && (half == 4'd15);

  // Counters sit at zero whenever no transfer is running, so each transfer starts clean.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      half   <= 4'd0;
      sd_clk <= 1'b0;
    end else if (!run) begin
      cnt    <= '0;
      half   <= 4'd0;
      sd_clk <= 1'b0;
    end else if (tick) begin
      cnt    <= '0;
      half   <= half + 4'd1;
      sd_clk <= ~sd_clk;
    end else begin
      cnt    <= cnt + {{(DIV_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: rtl/system_0_sd_spi_shifter.sv
// Avalon-MM SPI mode-0 byte shifter for the SD card; optional irq output under SD_SPI_IRQ_EN.
module system_0_sd_spi_shifter #(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 63
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic        read_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        sd_clk,
  output logic        sd_mosi,
  input  logic        sd_miso,
`ifdef SD_SPI_IRQ_EN
  output logic        irq,
`endif
  output logic        sd_cs_n
);
  import system_0_sd_pkg::*;

  state_t               state, state_next;
  logic [7:0]           shreg;
  logic [7:0]           rxdata;
  logic [DIV_WIDTH-1:0] div;
  logic                 done, overrun, cs_assert, busy, run;
  logic                 rise, fall, last;
  logic                 wr, rd, tx_wr, rx_rd, stat_wr, div_wr;
  logic                 unused_wd;

  assign wr        = chipselect & ~write_n;
  assign rd        = chipselect & ~read_n;
  assign tx_wr     = wr && (address == ADDR_TX);
  assign rx_rd     = rd && (address == ADDR_RX);
  assign stat_wr   = wr && (address == ADDR_STAT);
  assign div_wr    = wr && (address == ADDR_DIV);
  assign busy      = (state == SHIFT);
  assign run       = busy;
  assign unused_wd = ^writedata[31:9];

  system_0_sd_clkgen #(.DIV_WIDTH(DIV_WIDTH)) u_clkgen (
    .clk    (clk),
    .reset  (reset),
    .run    (run),
    .div    (div),
    .sd_clk (sd_clk),
    .rise   (rise),
    .fall   (fall),
    .last   (last)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tx_wr) state_next = SHIFT; else state_next = IDLE;
      SHIFT:   if (last)  state_next = DONE;  else state_next = SHIFT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath and register file. The shift happens on the rising edge together with
  // the sample, so bit 7 always holds the next bit to drive on the following fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= 8'd0;
      rxdata    <= 8'd0;
      sd_mosi   <= 1'b1;
      done      <= 1'b0;
      overrun   <= 1'b0;
      cs_assert <= 1'b0;
      sd_cs_n   <= 1'b1;
      div       <= DIV_WIDTH'(DEFAULT_DIV);
    end else begin
      if (state == IDLE && tx_wr) begin
        shreg   <= writedata[7:0];
        sd_mosi <= writedata[7];
      end else if (state == SHIFT) begin
        if (rise)          shreg   <= {shreg[6:0], sd_miso};
        if (fall && !last) sd_mosi <= shreg[7];
      end else if (state == DONE) begin
        rxdata  <= shreg;
        sd_mosi <= 1'b1;
      end

      if (state == DONE)                        done <= 1'b1;
      else if (rx_rd || (stat_wr && writedata[1])) done <= 1'b0;

      if (tx_wr && state != IDLE)          overrun <= 1'b1;
      else if (stat_wr && writedata[2])    overrun <= 1'b0;

      if (stat_wr) begin
        cs_assert <= writedata[8];
        sd_cs_n   <= ~writedata[8];
      end

      if (div_wr && state == IDLE) div <= writedata[DIV_WIDTH-1:0];
    end
  end

`ifdef SD_SPI_IRQ_EN
  logic irq_en;

  // Interrupt enable and registered interrupt output.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (stat_wr) irq_en <= writedata[16];
      irq <= done & irq_en;
    end
  end
`endif

  // Zero-latency read mux.
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_TX:   readdata = 32'd0;
      ADDR_RX:   readdata[7:0] = rxdata;
      ADDR_STAT: begin
        readdata[ST_BUSY]    = busy;
        readdata[ST_DONE]    = done;
        readdata[ST_OVERRUN] = overrun;
        readdata[ST_CS]      = cs_assert;
`ifdef SD_SPI_IRQ_EN
        readdata[ST_IRQ_EN]  = irq_en;
`endif
      end
      ADDR_DIV:  readdata[DIV_WIDTH-1:0] = div;
      default:   readdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_system_0_sd_spi_shifter.sv
// Directed self-checking bench for system_0_sd_spi_shifter (define SD_SPI_IRQ_EN to cover irq).
module tb_system_0_sd_spi_shifter;
  import system_0_sd_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect, write_n, read_n;
  logic [31:0] writedata, readdata;
  logic        sd_clk, sd_mosi, sd_miso, sd_cs_n;
`ifdef SD_SPI_IRQ_EN
  logic        irq;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic       loop_en;
  logic [7:0] resp_byte;
  int fall_base;
  int k;
  int fall_cnt = 0, rise_cnt = 0, cyc = 0, mosi_zero_cnt = 0;
  int last_rise_cyc = 0, prev_rise_cyc = 0;

  system_0_sd_spi_shifter #(.DIV_WIDTH(8), .DEFAULT_DIV(63)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .sd_clk     (sd_clk),
    .sd_mosi    (sd_mosi),
    .sd_miso    (sd_miso),
`ifdef SD_SPI_IRQ_EN
    .irq        (irq),
`endif
    .sd_cs_n    (sd_cs_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (sd_mosi === 1'b0) mosi_zero_cnt <= mosi_zero_cnt + 1;
  always @(negedge sd_clk) fall_cnt <= fall_cnt + 1;
  always @(posedge sd_clk) begin
    rise_cnt      <= rise_cnt + 1;
    prev_rise_cyc <= last_rise_cyc;
    last_rise_cyc <= cyc;
  end

  // Card model: loopback, or a response byte presented MSB first, advancing on each fall.
  always_comb begin
    k = fall_cnt - fall_base;
    if (loop_en)               sd_miso = sd_mosi;
    else if (k >= 0 && k < 8)  sd_miso = resp_byte[3'(7 - k)];
    else                       sd_miso = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; read_n = 1'b0;
    #1 d = readdata;
    @(posedge clk); #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  task automatic peek(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1 d = readdata;
  endtask

  task automatic wait_idle(output int n);
    logic [31:0] s;
    n = 0;
    peek(ADDR_STAT, s);
    while (s[0] && n < 5000) begin
      @(posedge clk); #1;
      n++;
      peek(ADDR_STAT, s);
    end
    chk("busy_bound", 32'(n < 5000), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    int n, r0, z0;
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    address = 2'd0; writedata = 32'd0;
    loop_en = 1'b1; resp_byte = 8'hFF; fall_base = 0;

    // Reset values
    repeat (3) @(posedge clk); #1;
    chk("rst_sd_clk",  32'(sd_clk),  32'd0);
    chk("rst_mosi",    32'(sd_mosi), 32'd1);
    chk("rst_cs_n",    32'(sd_cs_n), 32'd1);
    peek(ADDR_STAT, d); chk("rst_status", d, 32'h0);
    peek(ADDR_DIV, d);  chk("rst_clkdiv", d, 32'd63);
    peek(ADDR_RX, d);   chk("rst_rxdata", d, 32'h0);
    @(negedge clk); reset = 1'b0;

    // Loopback, div=0
    bus_write(ADDR_DIV, 32'd0);
    peek(ADDR_DIV, d); chk("div0_readback", d, 32'd0);
    r0 = rise_cnt;
    bus_write(ADDR_TX, 32'hA5);
    wait_idle(n);
    chk("lb_busy_cycles", 32'(n), 32'd16);
    chk("lb_rises", 32'(rise_cnt - r0), 32'd8);
    peek(ADDR_STAT, d); chk("lb_done_not_yet", d, 32'h0);
    @(posedge clk); #1;
    peek(ADDR_STAT, d); chk("lb_done_set", d, 32'h2);
    bus_read(ADDR_RX, d); chk("lb_rxdata", d, 32'hA5);
    peek(ADDR_STAT, d); chk("lb_done_cleared", d, 32'h0);

    // Card response, div=3
    bus_write(ADDR_DIV, 32'd3);
    loop_en = 1'b0; resp_byte = 8'h01; fall_base = fall_cnt;
    r0 = rise_cnt; z0 = mosi_zero_cnt;
    bus_write(ADDR_TX, 32'hFF);
    wait_idle(n);
    chk("card_busy_cycles", 32'(n), 32'd64);
    chk("card_rises", 32'(rise_cnt - r0), 32'd8);
    chk("card_sck_period", 32'(last_rise_cyc - prev_rise_cyc), 32'd8);
    chk("card_mosi_high", 32'(mosi_zero_cnt - z0), 32'd0);
    @(posedge clk); #1;
    bus_read(ADDR_RX, d); chk("card_rxdata", d, 32'h01);

    // Overrun, divider write while busy, TXDATA write in the DONE cycle
    loop_en = 1'b1;
    bus_write(ADDR_DIV, 32'd0);
    bus_write(ADDR_TX, 32'h12);
    bus_write(ADDR_TX, 32'h34);
    bus_write(ADDR_DIV, 32'd9);
    wait_idle(n);
    peek(ADDR_STAT, d); chk("ovr_status_done_cycle", d, 32'h4);
    bus_write(ADDR_TX, 32'h56);
    peek(ADDR_STAT, d); chk("ovr_status_after", d, 32'h6);
    peek(ADDR_DIV, d);  chk("div_write_busy_ignored", d, 32'd0);
    bus_read(ADDR_RX, d); chk("ovr_rxdata", d, 32'h12);
    bus_write(ADDR_STAT, 32'h4);
    peek(ADDR_STAT, d); chk("ovr_cleared", d, 32'h0);

    // RXDATA read in the cycle done sets: set wins
    bus_write(ADDR_TX, 32'h3C);
    wait_idle(n);
    bus_read(ADDR_RX, d);
    peek(ADDR_STAT, d); chk("done_set_wins", d, 32'h2);
    bus_read(ADDR_RX, d); chk("sw_rxdata", d, 32'h3C);
    peek(ADDR_STAT, d); chk("sw_done_cleared", d, 32'h0);

    // Chip select, mid-transfer release, divider write in idle
    bus_write(ADDR_STAT, 32'h100);
    chk("cs_asserted", 32'(sd_cs_n), 32'd0);
    peek(ADDR_STAT, d); chk("cs_status", d, 32'h100);
    bus_write(ADDR_TX, 32'h5A);
    bus_write(ADDR_STAT, 32'h0);
    chk("cs_released_mid", 32'(sd_cs_n), 32'd1);
    peek(ADDR_STAT, d); chk("cs_busy_continues", d, 32'h1);
    wait_idle(n);
    @(posedge clk); #1;
    bus_read(ADDR_RX, d); chk("cs_rxdata", d, 32'h5A);
    bus_write(ADDR_DIV, 32'd5);
    peek(ADDR_DIV, d); chk("div5_readback", d, 32'd5);

    // Reset mid-transfer
    bus_write(ADDR_STAT, 32'h100);
    bus_write(ADDR_TX, 32'h3C);
    repeat (20) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_sd_clk", 32'(sd_clk),  32'd0);
    chk("mid_rst_mosi",   32'(sd_mosi), 32'd1);
    chk("mid_rst_cs_n",   32'(sd_cs_n), 32'd1);
    peek(ADDR_STAT, d); chk("mid_rst_status", d, 32'h0);
    peek(ADDR_DIV, d);  chk("mid_rst_clkdiv", d, 32'd63);
    peek(ADDR_RX, d);   chk("mid_rst_rxdata", d, 32'h0);
    @(negedge clk); reset = 1'b0;

`ifdef SD_SPI_IRQ_EN
    bus_write(ADDR_DIV, 32'd0);
    bus_write(ADDR_STAT, 32'h10000);
    peek(ADDR_STAT, d); chk("irq_en_readback", d, 32'h10000);
    bus_write(ADDR_TX, 32'h81);
    wait_idle(n);
    chk("irq_low_in_done", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_low_when_done_sets", 32'(irq), 32'd0);
    @(posedge clk); #1;
    chk("irq_high", 32'(irq), 32'd1);
    bus_read(ADDR_RX, d); chk("irq_rxdata", d, 32'h81);
    @(posedge clk); #1;
    chk("irq_cleared", 32'(irq), 32'd0);
`else
    bus_write(ADDR_STAT, 32'h10000);
    peek(ADDR_STAT, d); chk("irq_en_absent", d, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
